act_pipe_unit: RTL and testbench

Streaming, multi-lane activation stage placed between the matrix-multiply accumulator output and the output buffer. It converts wide signed accumulator words into signed Q(OUT_WIDTH-8).8 results with saturation, then applies a per-beat selected activation: none, ReLU, Leaky ReLU, interpolated sigmoid or tanh. It has a 3-stage pipeline with valid/ready backpressure on both sides. The activation mode is captured with each accepted beat.

---
 rtl/act_pipe_unit.sv | 213 +++++++++++++++++++++
 tb/tb_act_pipe_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/act_pipe_unit.sv
// act_pipe_unit: 3-stage multi-lane scale/clamp + activation pipeline.
// Optional saturation beat counter enabled by defining ACT_SAT_CNT_EN.
module act_pipe_unit #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int LANES     = 8,
    parameter int IN_FRAC   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [LANES*IN_WIDTH-1:0]  s_data,
    input  logic [2:0]                 cfg_act,
    input  logic [3:0]                 cfg_leaky_shift,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [LANES*OUT_WIDTH-1:0] m_data,
    input  logic                       sat_clr,
    output logic [15:0]                sat_count
);

    localparam int SH = IN_FRAC - 8;
    localparam int W  = OUT_WIDTH;

    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] POS8 = W'(2048);
    localparam logic signed [W-1:0] NEG8 = -POS8;

    localparam logic [2:0] ACT_NONE  = 3'd0;
    localparam logic [2:0] ACT_RELU  = 3'd1;
    localparam logic [2:0] ACT_LEAKY = 3'd2;
    localparam logic [2:0] ACT_SIG   = 3'd3;
    localparam logic [2:0] ACT_TANH  = 3'd4;

    function automatic logic [8:0] lut(input logic [4:0] i);
        case (i)
            5'd0:    lut = 9'd0;
            5'd1:    lut = 9'd0;
            5'd2:    lut = 9'd1;
            5'd3:    lut = 9'd2;
            5'd4:    lut = 9'd5;
            5'd5:    lut = 9'd12;
            5'd6:    lut = 9'd31;
            5'd7:    lut = 9'd69;
            5'd8:    lut = 9'd128;
            5'd9:    lut = 9'd187;
            5'd10:   lut = 9'd225;
            5'd11:   lut = 9'd244;
            5'd12:   lut = 9'd251;
            5'd13:   lut = 9'd254;
            5'd14:   lut = 9'd255;
            default: lut = 9'd256;
        endcase
    endfunction

    logic en;
    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    // S1: scale and clamp
    logic signed [IN_WIDTH-1:0] xw_d  [LANES];
    logic        [W:0]          dbl_d [LANES];
    logic signed [W-1:0]        x_d   [LANES];
    logic signed [W-1:0]        x2_d  [LANES];
    logic        [LANES-1:0]    sat_d;

    always_comb begin
        sat_d = '0;
        for (int i = 0; i < LANES; i++) begin
            xw_d[i] = $signed(s_data[i*IN_WIDTH +: IN_WIDTH]) >>> SH;
            sat_d[i] = !((&xw_d[i][IN_WIDTH-1:W-1]) ||
                         !(|xw_d[i][IN_WIDTH-1:W-1]));
            if (sat_d[i])
                x_d[i] = xw_d[i][IN_WIDTH-1] ? MINV : MAXV;
            else
                x_d[i] = xw_d[i][W-1:0];
            dbl_d[i] = {x_d[i], 1'b0};
            if (dbl_d[i][W] != dbl_d[i][W-1])
                x2_d[i] = dbl_d[i][W] ? MINV : MAXV;
            else
                x2_d[i] = dbl_d[i][W-1:0];
        end
    end

    logic                v1_q;
    logic [2:0]          m1_q;
    logic [3:0]          sh1_q;
    logic                sat1_q;
    logic signed [W-1:0] x1_q  [LANES];
    logic signed [W-1:0] x21_q [LANES];

    // S2: segment select
    logic signed [W-1:0] a_d  [LANES];
    logic                hi_d [LANES];
    logic                lo_d [LANES];
    logic [3:0]          k_d  [LANES];
    logic [7:0]          f_d  [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_d[i]  = (m1_q == ACT_TANH) ? x21_q[i] : x1_q[i];
            hi_d[i] = a_d[i] >= POS8;
            lo_d[i] = a_d[i] < NEG8;
            k_d[i]  = {~a_d[i][11], a_d[i][10:8]};
            f_d[i]  = a_d[i][7:0];
        end
    end

    logic                v2_q;
    logic [2:0]          m2_q;
    logic [3:0]          sh2_q;
    logic signed [W-1:0] x2q  [LANES];
    logic                hi2q [LANES];
    logic                lo2q [LANES];
    logic [3:0]          k2q  [LANES];
    logic [7:0]          f2q  [LANES];

    // S3: activation output
    logic [8:0]           lo_v [LANES];
    logic [8:0]           hi_v [LANES];
    logic [16:0]          prod [LANES];
    logic [8:0]           y    [LANES];
    logic [10:0]          t    [LANES];
    logic [LANES*W-1:0]   res_d;

    always_comb begin
        res_d = '0;
        for (int i = 0; i < LANES; i++) begin
            lo_v[i] = lut({1'b0, k2q[i]});
            hi_v[i] = lut({1'b0, k2q[i]} + 5'd1);
            prod[i] = 17'(hi_v[i] - lo_v[i]) * 17'(f2q[i]);
            y[i]    = lo_v[i] + 9'(prod[i] >> 8);
            if (hi2q[i])
                y[i] = 9'd256;
            else if (lo2q[i])
                y[i] = 9'd0;
            t[i] = {1'b0, y[i], 1'b0} - 11'd256;
            case (m2_q)
                ACT_RELU:
                    res_d[i*W +: W] = x2q[i][W-1] ? '0 : x2q[i];
                ACT_LEAKY:
                    res_d[i*W +: W] = x2q[i][W-1] ? (x2q[i] >>> sh2_q)
                                                  : x2q[i];
                ACT_SIG:
                    res_d[i*W +: W] = {{(W-9){1'b0}}, y[i]};
                ACT_TANH:
                    res_d[i*W +: W] = {{(W-11){t[i][10]}}, t[i]};
                default:
                    res_d[i*W +: W] = x2q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            m1_q    <= ACT_NONE;
            sh1_q   <= '0;
            sat1_q  <= 1'b0;
            x1_q    <= '{default: '0};
            x21_q   <= '{default: '0};
            v2_q    <= 1'b0;
            m2_q    <= ACT_NONE;
            sh2_q   <= '0;
            x2q     <= '{default: '0};
            hi2q    <= '{default: 1'b0};
            lo2q    <= '{default: 1'b0};
            k2q     <= '{default: '0};
            f2q     <= '{default: '0};
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (en) begin
            v1_q    <= s_valid;
            m1_q    <= cfg_act;
            sh1_q   <= cfg_leaky_shift;
            sat1_q  <= |sat_d;
            x1_q    <= x_d;
            x21_q   <= x2_d;
            v2_q    <= v1_q;
            m2_q    <= m1_q;
            sh2_q   <= sh1_q;
            x2q     <= x1_q;
            hi2q    <= hi_d;
            lo2q    <= lo_d;
            k2q     <= k_d;
            f2q     <= f_d;
            m_valid <= v2_q;
            m_data  <= res_d;
        end
    end

`ifdef ACT_SAT_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (sat_clr)
            cnt_q <= '0;
        else if (en && v1_q && sat1_q && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign sat_count = cnt_q;
`else
    logic unused_sat;
    assign unused_sat = sat_clr ^ sat1_q;
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_act_pipe_unit.sv
// Directed self-checking bench for act_pipe_unit.
module tb_act_pipe_unit;

    localparam int IW = 32;
    localparam int OW = 16;
    localparam int L  = 8;
    localparam int NT = 20;
    localparam int NS = 10;
`ifdef ACT_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [L*IW-1:0] s_data = '0;
    logic [2:0]      cfg_act = '0;
    logic [3:0]      cfg_leaky_shift = '0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [L*OW-1:0] m_data;
    logic            sat_clr = 1'b0;
    logic [15:0]     sat_count;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    act_pipe_unit dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_act(cfg_act), .cfg_leaky_shift(cfg_leaky_shift),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    logic [31:0] tv_in [NT] = '{
        32'h0001_8000, 32'hFFFF_0000, 32'h0001_8000, 32'hFFFF_0000,
        32'hFFFF_0000, 32'h0001_8000, 32'h0000_8000, 32'h0000_0000,
        32'h0009_0000, 32'hFFF7_0000, 32'h0002_4000, 32'hFFF8_0000,
        32'h0001_0000, 32'hFFF7_0000, 32'h0000_4000, 32'hFFFF_0000,
        32'hFFFF_FF01, 32'h7FFF_0000, 32'h8000_0000, 32'h0008_0000};
    logic [2:0] tv_act [NT] = '{
        3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
        3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3};
    logic [3:0] tv_sh [NT] = '{
        4'd0, 4'd0, 4'd0, 4'd3, 4'd15, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0,
        4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [15:0] tv_exp [NT] = '{
        16'h0180, 16'h0000, 16'h0180, 16'hFFE0, 16'hFFFF, 16'h0180,
        16'h009D, 16'h0080, 16'h0100, 16'h0000, 16'h00E5, 16'h0000,
        16'h00C2, 16'hFF00, 16'h003A, 16'hFF00, 16'hFFFF, 16'h7FFF,
        16'h8000, 16'h0100};
    bit tv_sat [NT] = '{
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    int sel [NS] = '{0, 6, 12, 3, 1, 7, 13, 15, 10, 14};

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [L*IW-1:0] rep_in(input logic [31:0] v);
        return {L{v}};
    endfunction

    function automatic logic [L*OW-1:0] rep_out(input logic [15:0] v);
        return {L{v}};
    endfunction

    task automatic run_beat(input string tag, input logic [L*IW-1:0] d,
                            input logic [2:0] act, input logic [3:0] sh,
                            input logic [L*OW-1:0] exp);
        @(negedge clk);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = d;
        cfg_act = act;
        cfg_leaky_shift = sh;
        #1 check({tag, " s_ready"}, 128'(s_ready), 128'(1));
        @(negedge clk);
        s_valid = 1'b0;
        s_data = '0;
        cfg_act = ~act;
        cfg_leaky_shift = ~sh;
        check({tag, " early1"}, 128'(m_valid), 128'(0));
        @(negedge clk);
        check({tag, " early2"}, 128'(m_valid), 128'(0));
        @(negedge clk);
        check({tag, " valid"}, 128'(m_valid), 128'(1));
        check({tag, " data"}, 128'(m_data), 128'(exp));
    endtask

    initial begin
        int exp_cnt;
        int in_i;
        int out_i;
        int cyc;
        bit stalled;
        logic [L*OW-1:0] snap;
        logic [L*IW-1:0] d;
        logic [L*OW-1:0] e;

        repeat (2) @(negedge clk);
        check("rst m_valid", 128'(m_valid), 128'(0));
        check("rst m_data", 128'(m_data), 128'(0));
        check("rst s_ready", 128'(s_ready), 128'(1));
        check("rst sat_count", 128'(sat_count), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle m_valid", 128'(m_valid), 128'(0));
        check("idle s_ready", 128'(s_ready), 128'(1));

        exp_cnt = 0;
        for (int i = 0; i < NT; i++) begin
            run_beat($sformatf("vec%0d", i), rep_in(tv_in[i]), tv_act[i],
                     tv_sh[i], rep_out(tv_exp[i]));
            if (tv_sat[i] && SAT_EN)
                exp_cnt++;
            check($sformatf("vec%0d sat_count", i), 128'(sat_count),
                  128'(exp_cnt));
        end

        for (int i = 0; i < L; i++) begin
            d[i*IW +: IW] = 32'(i) << 16;
            e[i*OW +: OW] = 16'(i) << 8;
        end
        run_beat("lanes", d, 3'd0, 4'd0, e);

        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check("sat_clr", 128'(sat_count), 128'(0));

        sat_clr = 1'b1;
        run_beat("clr_prio", rep_in(32'h7FFF_0000), 3'd0, 4'd0,
                 rep_out(16'h7FFF));
        sat_clr = 1'b0;
        check("clr_prio sat_count", 128'(sat_count), 128'(0));

        in_i = 0;
        out_i = 0;
        cyc = 0;
        stalled = 1'b0;
        snap = '0;
        while (out_i < NS && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("hold valid", 128'(m_valid), 128'(1));
                check("hold data", 128'(m_data), 128'(snap));
            end
            m_ready = 1'($urandom_range(0, 1));
            if (in_i < NS) begin
                s_valid = 1'b1;
                s_data = rep_in(tv_in[sel[in_i]]);
                cfg_act = tv_act[sel[in_i]];
                cfg_leaky_shift = tv_sh[sel[in_i]];
            end else begin
                s_valid = 1'b0;
            end
            #1;
            stalled = m_valid && !m_ready;
            snap = m_data;
            if (m_valid && m_ready) begin
                check($sformatf("stream beat %0d", out_i), 128'(m_data),
                      128'(rep_out(tv_exp[sel[out_i]])));
                out_i++;
            end
            if (s_valid && s_ready)
                in_i++;
        end
        if (out_i < NS)
            check("stream timeout", 128'(out_i), 128'(NS));
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stream drained", 128'(m_valid), 128'(0));
        end

        @(negedge clk);
        s_valid = 1'b1;
        s_data = rep_in(32'h0001_8000);
        cfg_act = 3'd0;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst m_valid", 128'(m_valid), 128'(0));
        check("midrst m_data", 128'(m_data), 128'(0));
        check("midrst s_ready", 128'(s_ready), 128'(1));
        check("midrst sat_count", 128'(sat_count), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst no output", 128'(m_valid), 128'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
